// File: rtl/sram_pkg.sv
// Shared types and helpers for the sram_pipe scratch SRAM.
package sram_pkg;

  typedef enum logic {
    CLEAR,
    READY
  } sram_state_e;

  localparam int RD_LATENCY_MAX = 4;

  // One byte lane of a strobed write: new byte where the strobe is set.
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       strb);
    return strb ? new_b : old_b;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-return pipeline for sram_pipe: RD_LATENCY-deep valid/data shift register.
module sram_rd_pipe #(
  parameter int DATA_WIDTH = 128,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0] data_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0] data_d [RD_LATENCY];

  // Data stages only load on a valid beat so the output holds between reads.
  always_comb begin
    vld_d[0]  = in_vld;
    data_d[0] = in_vld ? in_data : data_q[0];
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = vld_q[i-1] ? data_q[i-1] : data_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) data_q[i] <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign out_vld  = vld_q[RD_LATENCY-1];
  assign out_data = data_q[RD_LATENCY-1];

endmodule

// File: rtl/sram_pipe.sv
// 1W/1R SRAM with byte strobes, pipelined reads and a post-reset clear sweep.
// Define SRAM_BYPASS_EN for write-first collisions; otherwise read-first.
//
//   state | meaning
//   CLEAR | sweeping zeros into every word, requests ignored, ready=0
//   READY | normal operation until the next reset
module sram_pipe
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wen,
  input  logic [ADDR_WIDTH-1:0]   wadr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    ren,
  input  logic [ADDR_WIDTH-1:0]   radr,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid,
  output logic                    ready
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NB    = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  sram_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ready_q, ready_d;

  logic                  wr_in_range, rd_in_range, user_wr, rd_vld0;
  logic [DATA_WIDTH-1:0] old_word, merged_word, rd_data0, mem_wdata;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_widx;

  always_comb begin
    wr_in_range = int'(wadr) < DEPTH;
    rd_in_range = int'(radr) < DEPTH;
    user_wr     = ready_q && wen && wr_in_range && (wstrb != '0);
    rd_vld0     = ready_q && ren;

    old_word    = mem_q[IDX_W'(wadr)];
    merged_word = old_word;
    for (int i = 0; i < NB; i++) begin
      merged_word[8*i +: 8] = merge_byte(old_word[8*i +: 8], wdata[8*i +: 8], wstrb[i]);
    end

    rd_data0 = rd_in_range ? mem_q[IDX_W'(radr)] : '0;
`ifdef SRAM_BYPASS_EN
    if (user_wr && rd_vld0 && (wadr == radr)) rd_data0 = merged_word;
`endif

    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    mem_we    = 1'b0;
    mem_widx  = IDX_W'(wadr);
    mem_wdata = merged_word;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_widx  = IDX_W'(cnt_q);
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (int'(cnt_q) == DEPTH - 1) begin
          state_d = READY;
          ready_d = 1'b1;
          cnt_d   = '0;
        end
      end
      READY: mem_we = user_wr;
    endcase
    // No array update on a reset edge, whatever state we were in.
    if (!rst_n) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_widx] <= mem_wdata;
  end

  sram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (rd_vld0),
    .in_data  (rd_data0),
    .out_vld  (rvalid),
    .out_data (rdata)
  );

  assign ready = ready_q;

endmodule
